// File: rtl/time_set_ctrl_pkg.sv
// Shared types and BCD helpers for the time-setting controller.
// Holds FSM states, blink-select codes and field limits.
package time_set_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'b00;
  localparam logic [1:0] FIELD_HOUR = 2'b01;
  localparam logic [1:0] FIELD_MIN  = 2'b10;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;

  // With both nibbles <= 9, BCD ordering matches binary ordering.
  function automatic logic [7:0] bcd_clean(
    input logic [7:0] v,
    input logic [7:0] max
  );
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > max)
      return 8'h00;
    return v;
  endfunction

  function automatic logic [7:0] bcd_inc(
    input logic [7:0] v,
    input logic [7:0] max
  );
    if (v == max)
      return 8'h00;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/time_set_ctrl_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter,
// and a single-cycle pulse on each accepted 0->1 level change.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CMAX) begin
        // Level accepted on the Nth consecutive disagreeing cycle.
        level <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: mode/inc buttons drive a RUN/SET_HOUR/
// SET_MIN editor producing a BCD time and a load strobe.
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic [15:0] cur_time,
  output logic [15:0] set_time,
  output logic        set_load,
  output logic        set_active,
  output logic [1:0]  edit_field
);

  logic        mode_p;
  logic        inc_p;
  state_t      state;
  state_t      state_n;
  logic [15:0] edit;
  logic [15:0] edit_n;
  logic        load_n;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_mode (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_mode),
    .press(mode_p)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_inc (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_inc),
    .press(inc_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      edit     <= 16'h0000;
      set_load <= 1'b0;
    end else begin
      state    <= state_n;
      edit     <= edit_n;
      set_load <= load_n;
    end
  end

  // Mode wins over a same-cycle inc; that inc is dropped.
  always_comb begin
    state_n    = state;
    edit_n     = edit;
    load_n     = 1'b0;
    set_active = 1'b0;
    edit_field = FIELD_NONE;
    unique case (1'b1)
      (state == RUN): begin
        if (mode_p) begin
          state_n = SET_HOUR;
          edit_n  = {bcd_clean(cur_time[15:8], HOUR_MAX),
                     bcd_clean(cur_time[7:0], MIN_MAX)};
        end
      end
      (state == SET_HOUR): begin
        set_active = 1'b1;
        edit_field = FIELD_HOUR;
        if (mode_p)
          state_n = SET_MIN;
        else if (inc_p)
          edit_n[15:8] = bcd_inc(edit[15:8], HOUR_MAX);
      end
      (state == SET_MIN): begin
        set_active = 1'b1;
        edit_field = FIELD_MIN;
        if (mode_p) begin
          state_n = RUN;
          load_n  = 1'b1;
        end else if (inc_p) begin
          edit_n[7:0] = bcd_inc(edit[7:0], MIN_MAX);
        end
      end
      default: state_n = RUN;
    endcase
  end

  assign set_time = edit;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl with a short debounce window.
// Expected output tuples come from an integer hour/minute model.
module tb_time_set_ctrl;

  logic        clk;
  logic        rst;
  logic        btn_mode;
  logic        btn_inc;
  logic [15:0] cur_time;
  logic [15:0] set_time;
  logic        set_load;
  logic        set_active;
  logic [1:0]  edit_field;

  typedef struct packed {
    logic [15:0] t;
    logic        ld;
    logic        act;
    logic [1:0]  fld;
  } obs_t;

  obs_t expq[$];
  obs_t last_exp;
  obs_t prev;
  int   checks;
  int   fails;
  int   pend;
  bit   mon_en;

  int mst;
  int mh;
  int mm;

  time_set_ctrl #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .cur_time  (cur_time),
    .set_time  (set_time),
    .set_load  (set_load),
    .set_active(set_active),
    .edit_field(edit_field)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int h, input int m);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic obs_t model_obs(input bit ld);
    obs_t o;
    o.t   = to_bcd(mh, mm);
    o.ld  = ld;
    o.act = (mst != 0);
    o.fld = (mst == 1) ? 2'b01 : (mst == 2) ? 2'b10 : 2'b00;
    return o;
  endfunction

  function automatic int field_val(input logic [7:0] v, input int lim);
    int hi;
    int lo;
    int n;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi > 9 || lo > 9) return 0;
    n = hi * 10 + lo;
    return (n > lim) ? 0 : n;
  endfunction

  task automatic expect_obs(input obs_t o);
    if (o != last_exp) begin
      expq.push_back(o);
      last_exp = o;
    end
  endtask

  task automatic model_mode();
    case (mst)
      0: begin
        mh  = field_val(cur_time[15:8], 23);
        mm  = field_val(cur_time[7:0], 59);
        mst = 1;
        expect_obs(model_obs(1'b0));
      end
      1: begin
        mst = 2;
        expect_obs(model_obs(1'b0));
      end
      default: begin
        mst = 0;
        expect_obs(model_obs(1'b1));
        expect_obs(model_obs(1'b0));
      end
    endcase
  endtask

  task automatic model_inc();
    if (mst == 1) mh = (mh + 1) % 24;
    if (mst == 2) mm = (mm + 1) % 60;
    expect_obs(model_obs(1'b0));
  endtask

  task automatic press(input bit m, input bit i, input int hold);
    if (m) model_mode();
    else if (i) model_inc();
    @(posedge clk);
    #1;
    btn_mode = m;
    btn_inc  = i;
    repeat (hold) @(posedge clk);
    #1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  task automatic set_cur(input logic [15:0] v);
    @(posedge clk);
    #1;
    cur_time = v;
  endtask

  task automatic do_reset();
    mst = 0;
    mh  = 0;
    mm  = 0;
    expect_obs(model_obs(1'b0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  // Any change in the output tuple is a DUT response to be scored.
  always @(negedge clk) begin
    obs_t cur;
    obs_t e;
    if (mon_en) begin
      cur = {set_time, set_load, set_active, edit_field};
      if (cur != prev) begin
        checks++;
        if (expq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change: got t=%h ld=%b act=%b fld=%b, none expected",
                   cur.t, cur.ld, cur.act, cur.fld);
        end else begin
          e = expq.pop_front();
          pend = 0;
          if (cur != e) begin
            fails++;
            $display("FAIL output: got t=%h ld=%b act=%b fld=%b, want t=%h ld=%b act=%b fld=%b",
                     cur.t, cur.ld, cur.act, cur.fld, e.t, e.ld, e.act, e.fld);
          end
        end
      end
      if (expq.size() != 0) begin
        pend++;
        if (pend > 40) begin
          e = expq.pop_front();
          pend = 0;
          checks++;
          fails++;
          $display("FAIL timeout: no response, want t=%h ld=%b act=%b fld=%b",
                   e.t, e.ld, e.act, e.fld);
        end
      end
      prev = cur;
    end
  end

  initial begin
    obs_t r;
    int n;
    checks   = 0;
    fails    = 0;
    pend     = 0;
    mon_en   = 1'b0;
    mst      = 0;
    mh       = 0;
    mm       = 0;
    last_exp = '0;
    rst      = 1'b1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    cur_time = 16'h2358;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    r = {set_time, set_load, set_active, edit_field};
    checks++;
    if (r != '0) begin
      fails++;
      $display("FAIL reset_state: got %h, want %h", r, 20'h0);
    end
    prev   = r;
    mon_en = 1'b1;

    // Bouncing mode button settles into one press.
    model_mode();
    @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) begin
      btn_mode = ~btn_mode;
      repeat (2) @(posedge clk);
      #1;
    end
    btn_mode = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    btn_mode = 1'b0;
    repeat (12) @(posedge clk);
    press(0, 1, 10);
    press(1, 0, 10);
    press(0, 1, 10);
    press(0, 1, 10);
    press(1, 0, 10);

    // Inc in RUN is ignored; minute carry and wrap.
    press(0, 1, 10);
    set_cur(16'h1009);
    press(1, 0, 10);
    press(1, 0, 10);
    press(0, 1, 10);
    press(1, 0, 10);
    set_cur(16'h1059);
    press(1, 0, 10);
    press(1, 0, 10);
    press(0, 1, 10);
    press(1, 0, 10);

    // Invalid captures.
    set_cur(16'h2575);
    press(1, 0, 10);
    press(1, 0, 10);
    press(1, 0, 10);
    set_cur(16'h1A30);
    press(1, 0, 10);
    press(1, 0, 10);
    press(1, 0, 10);

    // Same-cycle mode+inc, then a long inc hold.
    set_cur(16'h0959);
    press(1, 0, 10);
    press(0, 1, 10);
    press(1, 1, 10);
    press(0, 1, 100);
    press(1, 0, 10);

    // Reset abandons an edit in SET_MIN.
    set_cur(16'h1234);
    press(1, 0, 10);
    press(1, 0, 10);
    do_reset();

    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 1)
        set_cur(to_bcd($urandom_range(0, 23), $urandom_range(0, 59)));
      else
        set_cur(16'($urandom));
      press(1, 0, $urandom_range(6, 14));
      n = $urandom_range(0, 4);
      for (int j = 0; j < n; j++) press(0, 1, $urandom_range(6, 14));
      press(1, 0, $urandom_range(6, 14));
      n = $urandom_range(0, 4);
      for (int j = 0; j < n; j++) press(0, 1, $urandom_range(6, 14));
      if ($urandom_range(0, 3) == 0) do_reset();
      else press(1, 0, $urandom_range(6, 14));
    end

    for (int w = 0; w < 100 && expq.size() != 0; w++) @(posedge clk);
    repeat (3) @(posedge clk);
    checks++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, want 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
